// File: rtl/macc_requant_relu_pkg.sv
// Shared constants for the MACC array output requantisation stage.
package macc_requant_relu_pkg;

  // Taps per MACC window; sets accumulator growth shared with the MACC array
  localparam int unsigned NUM_INPUTS      = 9;
  localparam int unsigned NUM_MACC        = 5;
  localparam int unsigned IN_WIDTH        = 16 + $clog2(NUM_INPUTS);
  localparam int unsigned BIAS_WIDTH      = 16;
  localparam int unsigned SCALE_WIDTH     = 16;
  localparam int unsigned SHIFT_WIDTH     = 5;
  localparam int unsigned OUT_WIDTH       = 8;

  // Pipeline depth from sampled input to registered output
  localparam int unsigned REQUANT_LATENCY = 4;

  // Signed int8 saturation bounds
  localparam int          OUT_MIN         = -128;
  localparam int          OUT_MAX         = 127;

endpackage

// File: rtl/macc_requant_relu_lane.sv
// One channel of bias add, scale, rounding shift, ReLU and int8 saturation.
module macc_requant_relu_lane
  import macc_requant_relu_pkg::*;
#(
  parameter int unsigned IN_W    = 20,
  parameter int unsigned BIAS_W  = 16,
  parameter int unsigned SCALE_W = 16,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en_s1,
  input  logic                      i_en_s2,
  input  logic                      i_en_s3,
  input  logic                      i_en_s4,
  input  logic signed [IN_W-1:0]    i_acc,
  input  logic signed [BIAS_W-1:0]  i_bias,
  input  logic        [SCALE_W-1:0] i_scale,
  input  logic        [SHIFT_W-1:0] i_shift,
  input  logic                      i_relu,
  output logic signed [OUT_WIDTH-1:0] o_q
);

  localparam int unsigned SUM_W  = ((IN_W > BIAS_W) ? IN_W : BIAS_W) + 1;
  localparam int unsigned PROD_W = SUM_W + SCALE_W + 1;
  localparam int unsigned RND_W  = PROD_W + 1;

  logic signed [SUM_W-1:0]     r_sum;
  logic        [SCALE_W-1:0]   r_scale;
  logic signed [PROD_W-1:0]    r_prod;
  logic signed [RND_W-1:0]     r_rnd;
  logic signed [RND_W-1:0]     w_half;
  logic signed [RND_W-1:0]     w_rnd;
  logic signed [RND_W-1:0]     w_relu_v;
  logic signed [OUT_WIDTH-1:0] w_q;

  // S1: widened bias add; scale is captured alongside for use in S2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_scale <= '0;
    end else if (i_en_s1) begin
      r_sum   <= SUM_W'(i_acc) + SUM_W'(i_bias);
      r_scale <= i_scale;
    end
  end

  // S2: signed sum times zero-extended unsigned scale (DSP multiply)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod <= '0;
    end else if (i_en_s2) begin
      r_prod <= PROD_W'(r_sum) * PROD_W'($signed({1'b0, r_scale}));
    end
  end

  // S3 combinational: half-LSB add then arithmetic shift (round half toward +inf)
  always_comb begin
    w_half = '0;
    if (i_shift != '0) begin
      w_half = RND_W'(1) << (i_shift - SHIFT_W'(1));
    end
    w_rnd = (RND_W'(r_prod) + w_half) >>> i_shift;
  end

  // S3: register the rounded value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rnd <= '0;
    end else if (i_en_s3) begin
      r_rnd <= w_rnd;
    end
  end

  // S4 combinational: optional ReLU then clamp to int8
  always_comb begin
    w_relu_v = r_rnd;
    if (i_relu && r_rnd[RND_W-1]) begin
      w_relu_v = '0;
    end
    w_q = w_relu_v[OUT_WIDTH-1:0];
    if (w_relu_v > RND_W'(OUT_MAX)) begin
      w_q = OUT_WIDTH'(OUT_MAX);
    end else if (w_relu_v < RND_W'(OUT_MIN)) begin
      w_q = OUT_WIDTH'(OUT_MIN);
    end
  end

  // S4: output register, held while no beat arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q <= '0;
    end else if (i_en_s4) begin
      o_q <= w_q;
    end
  end

endmodule

// File: rtl/macc_requant_relu.sv
// Per-channel requantisation output stage behind the MACC array.
module macc_requant_relu
  import macc_requant_relu_pkg::*;
#(
  parameter int unsigned NUM_MACC    = macc_requant_relu_pkg::NUM_MACC,
  parameter int unsigned IN_WIDTH    = macc_requant_relu_pkg::IN_WIDTH,
  parameter int unsigned BIAS_WIDTH  = macc_requant_relu_pkg::BIAS_WIDTH,
  parameter int unsigned SCALE_WIDTH = macc_requant_relu_pkg::SCALE_WIDTH,
  parameter int unsigned SHIFT_WIDTH = macc_requant_relu_pkg::SHIFT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic [OUT_WIDTH*NUM_MACC-1:0]   o_data,
  output logic                            o_valid,
  input  logic [IN_WIDTH*NUM_MACC-1:0]    i_data,
  input  logic [BIAS_WIDTH*NUM_MACC-1:0]  i_bias,
  input  logic [SCALE_WIDTH*NUM_MACC-1:0] i_scale,
  input  logic [SHIFT_WIDTH-1:0]          i_shift,
  input  logic                            i_relu,
  input  logic                            i_valid
);

  logic [REQUANT_LATENCY-1:0]    r_vld;
  logic [SHIFT_WIDTH-1:0]        r_shift_s1;
  logic [SHIFT_WIDTH-1:0]        r_shift_s2;
  logic                          r_relu_s1;
  logic                          r_relu_s2;
  logic                          r_relu_s3;
  logic [OUT_WIDTH*NUM_MACC-1:0] w_data;

  // Shared stage-valid shift register; bit k enables stage k+2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[REQUANT_LATENCY-2:0], i_valid};
    end
  end

  // Shift/ReLU controls travel with their beat, advancing only on valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift_s1 <= '0;
      r_shift_s2 <= '0;
      r_relu_s1  <= 1'b0;
      r_relu_s2  <= 1'b0;
      r_relu_s3  <= 1'b0;
    end else begin
      if (i_valid) begin
        r_shift_s1 <= i_shift;
        r_relu_s1  <= i_relu;
      end
      if (r_vld[0]) begin
        r_shift_s2 <= r_shift_s1;
        r_relu_s2  <= r_relu_s1;
      end
      if (r_vld[1]) begin
        r_relu_s3 <= r_relu_s2;
      end
    end
  end

  // Independent data path per channel
  for (genvar k = 0; k < NUM_MACC; k++) begin : g_lane
    macc_requant_relu_lane #(
      .IN_W    (IN_WIDTH),
      .BIAS_W  (BIAS_WIDTH),
      .SCALE_W (SCALE_WIDTH),
      .SHIFT_W (SHIFT_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_en_s1 (i_valid),
      .i_en_s2 (r_vld[0]),
      .i_en_s3 (r_vld[1]),
      .i_en_s4 (r_vld[2]),
      .i_acc   ($signed(i_data[IN_WIDTH*k +: IN_WIDTH])),
      .i_bias  ($signed(i_bias[BIAS_WIDTH*k +: BIAS_WIDTH])),
      .i_scale (i_scale[SCALE_WIDTH*k +: SCALE_WIDTH]),
      .i_shift (r_shift_s2),
      .i_relu  (r_relu_s3),
      .o_q     (w_data[OUT_WIDTH*k +: OUT_WIDTH])
    );
  end

  assign o_data  = w_data;
  assign o_valid = r_vld[REQUANT_LATENCY-1];

endmodule

// File: tb/tb_macc_requant_relu.sv
// Directed self-checking bench for macc_requant_relu.
module tb_macc_requant_relu;
  import macc_requant_relu_pkg::*;

  localparam int unsigned DW = OUT_WIDTH * NUM_MACC;

  logic                            clk = 1'b0;
  logic                            rst;
  logic [DW-1:0]                   o_data;
  logic                            o_valid;
  logic [IN_WIDTH*NUM_MACC-1:0]    i_data;
  logic [BIAS_WIDTH*NUM_MACC-1:0]  i_bias;
  logic [SCALE_WIDTH*NUM_MACC-1:0] i_scale;
  logic [SHIFT_WIDTH-1:0]          i_shift;
  logic                            i_relu;
  logic                            i_valid;

  int n_total = 0;
  int n_bad   = 0;

  macc_requant_relu dut (
    .clk     (clk),
    .rst     (rst),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_data  (i_data),
    .i_bias  (i_bias),
    .i_scale (i_scale),
    .i_shift (i_shift),
    .i_relu  (i_relu),
    .i_valid (i_valid)
  );

  always #5 clk = ~clk;

  // Drive identical values on every lane
  task automatic apply_all(input int acc, input int bias, input int scale,
                           input int shift, input int relu, input int vld);
    for (int k = 0; k < int'(NUM_MACC); k++) begin
      i_data[IN_WIDTH*k +: IN_WIDTH]          = IN_WIDTH'(acc);
      i_bias[BIAS_WIDTH*k +: BIAS_WIDTH]      = BIAS_WIDTH'(bias);
      i_scale[SCALE_WIDTH*k +: SCALE_WIDTH]   = SCALE_WIDTH'(scale);
    end
    i_shift = SHIFT_WIDTH'(shift);
    i_relu  = relu[0];
    i_valid = vld[0];
  endtask

  function automatic logic [DW-1:0] rep(input int v);
    logic [DW-1:0] r;
    for (int k = 0; k < int'(NUM_MACC); k++) r[OUT_WIDTH*k +: OUT_WIDTH] = OUT_WIDTH'(v);
    return r;
  endfunction

  // Present one beat for one edge, then wait until its output edge
  task automatic run_beat(input int acc, input int bias, input int scale,
                          input int shift, input int relu);
    apply_all(acc, bias, scale, shift, relu, 1);
    @(posedge clk); #1;
    apply_all(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply_all(55, 0, 1, 0, 0, 1);
    #1;
    n_total++;
    if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    n_total++;
    if (o_data !== '0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", o_data); end
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid_ignored got=%b exp=0", o_valid); end
    apply_all(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if (o_valid !== 1'b0 || o_data !== '0) begin
      n_bad++; $display("FAIL reset_release got_v=%b got_d=%h exp=0/0", o_valid, o_data);
    end
  endtask

  task automatic test_basic();
    apply_all(100, -20, 256, 8, 0, 1);
    @(posedge clk); #1;
    apply_all(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (o_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early got=%b exp=0", o_valid); end
    @(posedge clk); #1;
    n_total++;
    if (o_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%b exp=1", o_valid); end
    n_total++;
    if (o_data !== rep(80)) begin n_bad++; $display("FAIL basic_data got=%h exp=%h", o_data, rep(80)); end
    @(posedge clk); #1;
    n_total++;
    if (o_valid !== 1'b0 || o_data !== rep(80)) begin
      n_bad++; $display("FAIL basic_hold got_v=%b got_d=%h exp=0/%h", o_valid, o_data, rep(80));
    end
  endtask

  task automatic test_rounding();
    int acc_t[3] = '{3, -3, 5};
    int exp_t[3] = '{2, -1, 3};
    for (int i = 0; i < 3; i++) begin
      run_beat(acc_t[i], 0, 1, 1, 0);
      n_total++;
      if (o_valid !== 1'b1 || o_data !== rep(exp_t[i])) begin
        n_bad++; $display("FAIL round_%0d got_v=%b got_d=%h exp=1/%h", i, o_valid, o_data, rep(exp_t[i]));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sat_relu();
    int acc_t[4]  = '{1000, -1000, -1000, -5};
    int relu_t[4] = '{0, 0, 1, 1};
    int exp_t[4]  = '{127, -128, 0, 0};
    for (int i = 0; i < 4; i++) begin
      run_beat(acc_t[i], 0, 1, 0, relu_t[i]);
      n_total++;
      if (o_valid !== 1'b1 || o_data !== rep(exp_t[i])) begin
        n_bad++; $display("FAIL satrelu_%0d got_v=%b got_d=%h exp=1/%h", i, o_valid, o_data, rep(exp_t[i]));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lanes();
    logic [DW-1:0] exp_d;
    apply_all(0, 0, 1, 0, 0, 1);
    for (int k = 0; k < int'(NUM_MACC); k++) begin
      i_data[IN_WIDTH*k +: IN_WIDTH]     = IN_WIDTH'(10 * (k + 1));
      i_bias[BIAS_WIDTH*k +: BIAS_WIDTH] = BIAS_WIDTH'(k);
    end
    exp_d = {8'd54, 8'd43, 8'd32, 8'd21, 8'd10};
    @(posedge clk); #1;
    apply_all(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (o_valid !== 1'b1) begin n_bad++; $display("FAIL lanes_valid got=%b exp=1", o_valid); end
    n_total++;
    if (o_data !== exp_d) begin n_bad++; $display("FAIL lanes_data got=%h exp=%h", o_data, exp_d); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc_t[4]   = '{-40, 100, 0, -44};
    int shift_t[4] = '{0, 2, 0, 3};
    int relu_t[4]  = '{1, 0, 0, 0};
    int vld_t[4]   = '{1, 1, 0, 1};
    int expd_t[4]  = '{0, 25, 25, -5};
    int e;
    logic exp_v;
    for (int i = 0; i < 9; i++) begin
      if (i < 4) apply_all(acc_t[i], 0, 1, shift_t[i], relu_t[i], vld_t[i]);
      else       apply_all(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      e = i + 1;
      exp_v = (e >= 4 && e <= 7) ? vld_t[e-4][0] : 1'b0;
      n_total++;
      if (o_valid !== exp_v) begin
        n_bad++; $display("FAIL stream_valid_e%0d got=%b exp=%b", e, o_valid, exp_v);
      end
      if (e >= 4 && e <= 7) begin
        n_total++;
        if (o_data !== rep(expd_t[e-4])) begin
          n_bad++; $display("FAIL stream_data_e%0d got=%h exp=%h", e, o_data, rep(expd_t[e-4]));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      apply_all(50 + 10 * i, 0, 1, 0, 0, 1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    n_total++;
    if (o_valid !== 1'b0 || o_data !== '0) begin
      n_bad++; $display("FAIL midrst_clear got_v=%b got_d=%h exp=0/0", o_valid, o_data);
    end
    repeat (2) @(posedge clk);
    #1;
    apply_all(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (o_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_stale_%0d got=%b exp=0", i, o_valid); end
    end
    apply_all(7, 0, 1, 0, 0, 1);
    @(posedge clk); #1;
    apply_all(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (o_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_early got=%b exp=0", o_valid); end
    @(posedge clk); #1;
    n_total++;
    if (o_valid !== 1'b1 || o_data !== rep(7)) begin
      n_bad++; $display("FAIL midrst_next got_v=%b got_d=%h exp=1/%h", o_valid, o_data, rep(7));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_sat_relu();
    test_lanes();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/macc_requant_relu.md
# macc_requant_relu

Per-channel output stage that sits directly downstream of the 1-to-N MACC array. It takes the NUM_MACC wide accumulator results and applies the following steps, in a 4-stage valid-tagged pipeline:
- per-channel bias add
- per-channel fixed-point scale
- common rounding right-shift
- optional ReLU
- saturation to signed int8

Its int8 outputs feed the next layer's window/MACC input bus.

## Interface
- NUM_MACC, 5, number of parallel channels (matches MACC array)
- IN_WIDTH, 20, signed accumulator width per channel (16 + clog2(9))
- BIAS_WIDTH, 16, signed bias width per channel
- SCALE_WIDTH, 16, unsigned scale multiplier width per channel
- SHIFT_WIDTH, 5, width of common right-shift amount

Ports:
- clk  in  1  clock; all registers on rising edge
- rst  in  1  asynchronous, active-high reset
- o_data  out  8*NUM_MACC  signed int8 results, channel k at [8k+7:8k]
- o_valid  out  1  result valid
- i_data  in  IN_WIDTH*NUM_MACC  signed accumulators, channel k at [IN_WIDTH*(k+1)-1:IN_WIDTH*k]
- i_bias  in  BIAS_WIDTH*NUM_MACC  signed per-channel bias
- i_scale  in  SCALE_WIDTH*NUM_MACC  unsigned per-channel scale
- i_shift  in  SHIFT_WIDTH  common right-shift, 0..31
- i_relu  in  1  1 = clamp negatives to 0
- i_valid  in  1  input valid

## Operation
- All of i_data, i_bias, i_scale, i_shift and i_relu are sampled together in stage 1 when i_valid=1. i_shift and i_relu travel down the pipeline with their data.
- S1, add: s = acc + bias. Both operands are sign-extended to max(IN_WIDTH,BIAS_WIDTH)+1 = 21 bits, so there is no overflow.
- S2, scale: p = s * {1'b0, scale}. Signed result, 21+SCALE_WIDTH+1 = 38 bits.
- S3, round and shift:
  - If shift>0: r = (p + (1 << (shift-1))) >>> shift. This is round-half-toward-+inf.
  - If shift=0: r = p.
  - Rounding add is done at 39 bits, so there is no overflow.
- S4, ReLU and saturate:
  - If relu=1 and r<0, then r=0.
  - Then clamp to [-128, 127] and register into o_data.
- Each pipeline stage captures only when its valid bit is 1. Otherwise it holds its value.
- Lanes are independent. Per-channel outputs must never mix.

## Timing
- Latency is exactly 4 cycles: i_valid at edge N gives o_valid=1 after edge N+4.
- Throughput is 1 result vector per cycle. Back-to-back valids are fully pipelined.
- There is no backpressure. The consumer must accept every o_valid beat.
- Bubbles propagate: i_valid gaps appear as o_valid gaps with identical spacing.
- o_data holds its last value while o_valid=0.
- Reset:
  - The valid shift register (4 bits) and o_data clear to 0 asynchronously.
  - o_valid=0 immediately on rst assertion.
  - Intermediate data registers also clear to 0.
- Reset mid-operation: all in-flight beats are dropped. After rst deasserts, the first o_valid occurs exactly 4 cycles after the first sampled i_valid.
- i_valid high during rst is ignored.

## Structure
- Shared package/header holds:
  - OUT_MIN = -128 and OUT_MAX = 127
  - the IN_WIDTH derivation (16 + clog2(NUM_INPUTS)), shared with the MACC array
  - the pipeline latency constant REQUANT_LATENCY = 4
- Top level holds the single valid shift register, the i_shift/i_relu pipeline, and a generate loop over channels.
- One sub-module is natural: requant_lane. It holds one channel's S1–S4 data path and is enabled by the shared per-stage valid bits.
- Multiplier in S2 is mapped to DSP.

## Test plan
- Basic path: acc=100, bias=-20, scale=256, shift=8, relu=0 → o_data lane = 80, exactly 4 cycles later.
- Rounding, with scale=1, bias=0, shift=1:
  - acc=3 → 2
  - acc=-3 → -1
  - acc=5 → 3
- Saturation and ReLU, with scale=1, shift=0:
  - acc=1000 → 127
  - acc=-1000, relu=0 → -128
  - acc=-1000, relu=1 → 0
  - acc=-5, relu=1 → 0
- Lane independence: 5 lanes with acc=10,20,30,40,50, bias=k, scale=1, shift=0 → outputs 10,21,32,43,54 in correct lane positions.
- Streaming with gaps:
  - i_valid pattern 1,1,0,1 with changing shift/relu per beat → o_valid pattern 1,1,0,1 delayed by 4 cycles.
  - Each output uses its own beat's shift/relu.
  - o_data is held during the gap.
- Reset mid-stream: assert rst with 3 beats in flight → o_valid=0 and o_data=0 immediately, no stale beats after release, and the next beat emerges 4 cycles after its i_valid.
